// File: rtl/rv_pkg.sv
// Shared RV64I pipeline definitions: opcodes, ALUOp encodings and the ID/EX bundles.
package rv_pkg;

    localparam int unsigned XLEN = 64;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;

    // ALUOp handed to the ALU control unit
    localparam logic [1:0] ALUOP_R   = 2'b00;
    localparam logic [1:0] ALUOP_I   = 2'b01;
    localparam logic [1:0] ALUOP_MEM = 2'b10;
    localparam logic [1:0] ALUOP_BR  = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       mem_to_reg;
    } idex_ctrl_t;

    // Full ID/EX slot; all-zero is the bubble.
    typedef struct packed {
        logic            valid;
        idex_ctrl_t      ctrl;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
    } idex_reg_t;

endpackage

// File: rtl/id_ex_decode_if.sv
// ID-side request and ID/EX register outputs of the decoder.
interface id_ex_decode_if;
    import rv_pkg::*;

    logic            id_valid;
    logic [31:0]     id_instr;
    logic            stall_in;
    logic            flush_in;
    logic            hazard_stall;
    logic            illegal_instr;
    logic            ex_valid;
    logic [1:0]      ex_alu_op;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_imm;
    logic            ex_alu_src;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_branch;
    logic            ex_mem_to_reg;

    // Upstream/pipeline-control side
    modport master (
        output id_valid, id_instr, stall_in, flush_in,
        input  hazard_stall, illegal_instr, ex_valid, ex_alu_op, ex_funct3, ex_funct7,
        input  ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alu_src, ex_reg_write, ex_mem_read,
        input  ex_mem_write, ex_branch, ex_mem_to_reg
    );

    // Decoder side
    modport slave (
        input  id_valid, id_instr, stall_in, flush_in,
        output hazard_stall, illegal_instr, ex_valid, ex_alu_op, ex_funct3, ex_funct7,
        output ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alu_src, ex_reg_write, ex_mem_read,
        output ex_mem_write, ex_branch, ex_mem_to_reg
    );

endinterface

// File: rtl/imm_gen.sv
// Immediate generator: picks the I/S/B format from the opcode and sign-extends to XLEN.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    // funct3 and rs1 never contribute to an immediate here
    logic unused_bits;
    assign unused_bits = ^instr[19:12];

    // Format select and sign extension
    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_IMM, OP_IMM_32, LOAD: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            STORE:                   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:                  imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                                            instr[30:25], instr[11:8], 1'b0};
            default:                 imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_decode.sv
// Main decoder plus ID/EX register with load-use bubble insertion, stall and flush.
module id_ex_decode
    import rv_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    id_ex_decode_if.slave bus
);

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            legal;
    logic            rs2_used;
    idex_ctrl_t      dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            hazard;
    idex_reg_t       ex_q, ex_d;
    logic            illegal_q, illegal_d;

    assign opcode = bus.id_instr[6:0];
    assign rs1    = bus.id_instr[19:15];
    assign rs2    = bus.id_instr[24:20];

    imm_gen u_imm_gen (
        .instr (bus.id_instr),
        .imm   (dec_imm)
    );

    // Opcode decode into the control bundle
    always_comb begin
        dec_ctrl = '0;
        legal    = 1'b1;
        rs2_used = 1'b0;
        case (opcode)
            OP, OP_32: begin
                dec_ctrl.alu_op    = ALUOP_R;
                dec_ctrl.reg_write = 1'b1;
                rs2_used           = 1'b1;
            end
            OP_IMM, OP_IMM_32: begin
                dec_ctrl.alu_op    = ALUOP_I;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            LOAD: begin
                dec_ctrl.alu_op     = ALUOP_MEM;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
            end
            STORE: begin
                dec_ctrl.alu_op    = ALUOP_MEM;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                rs2_used           = 1'b1;
            end
            BRANCH: begin
                dec_ctrl.alu_op = ALUOP_BR;
                dec_ctrl.branch = 1'b1;
                rs2_used        = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Load in EX whose destination feeds this instruction: needs one bubble
    assign hazard = bus.id_valid & legal & ex_q.valid & ex_q.ctrl.mem_read &
                    (ex_q.rd != 5'd0) & ((ex_q.rd == rs1) | (rs2_used & (ex_q.rd == rs2)));

    assign bus.hazard_stall = hazard & ~bus.flush_in & ~bus.stall_in;

    // ID/EX next state: flush > stall > hazard > normal load
    always_comb begin
        ex_d      = ex_q;
        illegal_d = 1'b0;
        if (bus.flush_in) begin
            ex_d = '0;
        end else if (bus.stall_in) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = '0;
        end else if (bus.id_valid & legal) begin
            ex_d.valid  = 1'b1;
            ex_d.ctrl   = dec_ctrl;
            ex_d.funct3 = bus.id_instr[14:12];
            ex_d.funct7 = bus.id_instr[31:25];
            ex_d.rs1    = rs1;
            ex_d.rs2    = rs2;
            ex_d.rd     = bus.id_instr[11:7];
            ex_d.imm    = dec_imm;
        end else begin
            // Empty or illegal slot becomes a full bubble so control bits are zero
            ex_d      = '0;
            illegal_d = bus.id_valid & ~legal;
        end
    end

    // ID/EX register and illegal-instruction pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.illegal_instr = illegal_q;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_alu_op     = ex_q.ctrl.alu_op;
    assign bus.ex_alu_src    = ex_q.ctrl.alu_src;
    assign bus.ex_reg_write  = ex_q.ctrl.reg_write;
    assign bus.ex_mem_read   = ex_q.ctrl.mem_read;
    assign bus.ex_mem_write  = ex_q.ctrl.mem_write;
    assign bus.ex_branch     = ex_q.ctrl.branch;
    assign bus.ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
    assign bus.ex_funct3     = ex_q.funct3;
    assign bus.ex_funct7     = ex_q.funct7;
    assign bus.ex_rs1        = ex_q.rs1;
    assign bus.ex_rs2        = ex_q.rs2;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_imm        = ex_q.imm;

endmodule

// File: tb/tb_id_ex_decode.sv
// Bench for id_ex_decode: directed literal checks plus random traffic against a reference model.
module tb_id_ex_decode;
    import rv_pkg::*;

    localparam logic [31:0] I_ADD    = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_BEQ    = 32'hFE208EE3; // beq x1,x2,-4
    localparam logic [31:0] I_LD     = 32'h0080B283; // ld x5,8(x1)
    localparam logic [31:0] I_ADD6   = 32'h00228333; // add x6,x5,x2
    localparam logic [31:0] I_LD0    = 32'h0080B003; // ld x0,8(x1)
    localparam logic [31:0] I_ADD_X0 = 32'h00200333; // add x6,x0,x2

    typedef struct {
        bit        valid;
        bit [1:0]  alu_op;
        bit [2:0]  f3;
        bit [6:0]  f7;
        bit [4:0]  rs1, rs2, rd;
        bit [63:0] imm;
        bit        src, rw, mr, mw, br, m2r, rs2u;
    } m_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passes = 0;
    m_t   exp_ex;
    bit   exp_ill;

    always #5 clk = ~clk;

    id_ex_decode_if bus ();

    id_ex_decode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
        total++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    endfunction

    // Reference decode straight from the ISA field definitions
    function automatic void model_dec(input logic [31:0] ins, output bit legal, output m_t m);
        longint iimm, simm, bimm;
        m      = '{default: 0};
        legal  = 1'b1;
        iimm   = $signed(ins[31:20]);
        simm   = $signed({ins[31:25], ins[11:7]});
        bimm   = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        m.valid = 1'b1;
        m.f3   = ins[14:12];
        m.f7   = ins[31:25];
        m.rs1  = ins[19:15];
        m.rs2  = ins[24:20];
        m.rd   = ins[11:7];
        case (ins[6:0])
            7'h33, 7'h3B: begin m.alu_op = 0; m.rw = 1; m.rs2u = 1; end
            7'h13, 7'h1B: begin m.alu_op = 1; m.src = 1; m.rw = 1; m.imm = iimm; end
            7'h03: begin
                m.alu_op = 2; m.src = 1; m.mr = 1; m.m2r = 1; m.rw = 1; m.imm = iimm;
            end
            7'h23: begin m.alu_op = 2; m.src = 1; m.mw = 1; m.rs2u = 1; m.imm = simm; end
            7'h63: begin m.alu_op = 3; m.br = 1; m.rs2u = 1; m.imm = bimm; end
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic bit model_hz_raw();
        m_t d;
        bit lg;
        model_dec(bus.id_instr, lg, d);
        return bus.id_valid && lg && exp_ex.valid && exp_ex.mr && exp_ex.rd != 0 &&
               (exp_ex.rd == d.rs1 || (d.rs2u && exp_ex.rd == d.rs2));
    endfunction

    // Reference model of the ID/EX slot
    always @(posedge clk or negedge rst_n) begin
        m_t d;
        bit lg;
        if (!rst_n) begin
            exp_ex  <= '{default: 0};
            exp_ill <= 1'b0;
        end else begin
            model_dec(bus.id_instr, lg, d);
            exp_ill <= 1'b0;
            if (bus.flush_in) exp_ex <= '{default: 0};
            else if (bus.stall_in) exp_ex <= exp_ex;
            else if (model_hz_raw()) exp_ex <= '{default: 0};
            else if (bus.id_valid && lg) exp_ex <= d;
            else begin
                exp_ex  <= '{default: 0};
                exp_ill <= bus.id_valid && !lg;
            end
        end
    end

    // Compare DUT with the model mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            chk("hazard_stall", bus.hazard_stall,
                model_hz_raw() && !bus.flush_in && !bus.stall_in);
            chk("illegal_instr", bus.illegal_instr, exp_ill);
            chk("ex_valid", bus.ex_valid, exp_ex.valid);
            chk("ex_reg_write", bus.ex_reg_write, exp_ex.rw);
            chk("ex_mem_read", bus.ex_mem_read, exp_ex.mr);
            chk("ex_mem_write", bus.ex_mem_write, exp_ex.mw);
            chk("ex_branch", bus.ex_branch, exp_ex.br);
            chk("ex_mem_to_reg", bus.ex_mem_to_reg, exp_ex.m2r);
            chk("ex_alu_src", bus.ex_alu_src, exp_ex.src);
            if (exp_ex.valid) begin
                chk("ex_alu_op", bus.ex_alu_op, exp_ex.alu_op);
                chk("ex_funct3", bus.ex_funct3, exp_ex.f3);
                chk("ex_funct7", bus.ex_funct7, exp_ex.f7);
                chk("ex_rs1", bus.ex_rs1, exp_ex.rs1);
                chk("ex_rs2", bus.ex_rs2, exp_ex.rs2);
                chk("ex_rd", bus.ex_rd, exp_ex.rd);
                chk("ex_imm", bus.ex_imm, exp_ex.imm);
            end
        end
    end

    task automatic drive(bit v, logic [31:0] ins, bit st, bit fl);
        bus.id_valid = v;
        bus.id_instr = ins;
        bus.stall_in = st;
        bus.flush_in = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0]  opc_tab [8] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23, 7'h63, 7'h7F};
    logic [31:0] stall_ins [3] = '{I_LD, 32'hFFFFFFFF, I_BEQ};

    initial begin
        logic [31:0] ins;
        drive(0, 32'h0, 0, 0);
        #2;
        chk("reset ex_valid", bus.ex_valid, 0);
        chk("reset ex_alu_op", bus.ex_alu_op, 0);
        chk("reset ex_imm", bus.ex_imm, 0);
        chk("reset illegal", bus.illegal_instr, 0);
        #10 rst_n = 1'b1;
        tick();

        // add x3,x1,x2
        drive(1, I_ADD, 0, 0);
        chk("add no hazard", bus.hazard_stall, 0);
        tick();
        chk("add valid", bus.ex_valid, 1);
        chk("add alu_op", bus.ex_alu_op, 2'b00);
        chk("add funct3", bus.ex_funct3, 3'b000);
        chk("add funct7", bus.ex_funct7, 7'b0000000);
        chk("add rd", bus.ex_rd, 3);
        chk("add rs1", bus.ex_rs1, 1);
        chk("add rs2", bus.ex_rs2, 2);
        chk("add reg_write", bus.ex_reg_write, 1);
        chk("add alu_src", bus.ex_alu_src, 0);

        // beq
        drive(1, I_BEQ, 0, 0);
        tick();
        chk("beq alu_op", bus.ex_alu_op, 2'b11);
        chk("beq branch", bus.ex_branch, 1);
        chk("beq reg_write", bus.ex_reg_write, 0);
        chk("beq imm", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        // load-use: exactly one bubble
        drive(1, I_LD, 0, 0);
        tick();
        chk("ld mem_read", bus.ex_mem_read, 1);
        chk("ld rd", bus.ex_rd, 5);
        chk("ld imm", bus.ex_imm, 64'd8);
        drive(1, I_ADD6, 0, 0);
        chk("ld-use hazard", bus.hazard_stall, 1);
        tick();
        chk("ld-use bubble", bus.ex_valid, 0);
        chk("ld-use bubble rw", bus.ex_reg_write, 0);
        chk("ld-use hazard clears", bus.hazard_stall, 0);
        tick();
        chk("ld-use issue valid", bus.ex_valid, 1);
        chk("ld-use issue rs1", bus.ex_rs1, 5);
        chk("ld-use issue rd", bus.ex_rd, 6);

        // load to x0 never stalls
        drive(1, I_LD0, 0, 0);
        tick();
        drive(1, I_ADD_X0, 0, 0);
        chk("x0 no hazard", bus.hazard_stall, 0);
        tick();
        chk("x0 add issues", bus.ex_valid, 1);

        // illegal opcode
        drive(1, 32'hFFFFFFFF, 0, 0);
        tick();
        chk("illegal valid", bus.ex_valid, 0);
        chk("illegal pulse", bus.illegal_instr, 1);
        drive(0, 32'h0, 0, 0);
        tick();
        chk("illegal one cycle", bus.illegal_instr, 0);

        // stall holds, flush beats stall
        drive(1, I_ADD, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, stall_ins[i], 1, 0);
            chk("stall no hazard", bus.hazard_stall, 0);
            tick();
            chk("stall hold valid", bus.ex_valid, 1);
            chk("stall hold rd", bus.ex_rd, 3);
            chk("stall hold rs1", bus.ex_rs1, 1);
            chk("stall hold rs2", bus.ex_rs2, 2);
            chk("stall hold rw", bus.ex_reg_write, 1);
            chk("stall no illegal", bus.illegal_instr, 0);
        end
        drive(1, I_ADD, 1, 1);
        tick();
        chk("flush+stall bubble", bus.ex_valid, 0);
        chk("flush+stall rw", bus.ex_reg_write, 0);

        // async reset mid-stream
        drive(1, I_ADD, 0, 0);
        tick();
        chk("pre-reset valid", bus.ex_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", bus.ex_valid, 0);
        chk("async reset rd", bus.ex_rd, 0);
        chk("async reset rw", bus.ex_reg_write, 0);
        chk("async reset imm", bus.ex_imm, 0);
        tick();
        rst_n = 1'b1;
        drive(1, I_ADD, 0, 0);
        tick();
        chk("post-reset load", bus.ex_valid, 1);

        // random traffic; small register range so load-use collisions are common
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            if ($urandom_range(7, 0) != 0) begin
                ins[6:0]   = opc_tab[$urandom_range(7, 0)];
                ins[11:7]  = 5'($urandom_range(3, 0));
                ins[19:15] = 5'($urandom_range(3, 0));
                ins[24:20] = 5'($urandom_range(3, 0));
            end
            drive($urandom_range(3, 0) != 0, ins, $urandom_range(5, 0) == 0,
                  $urandom_range(7, 0) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
